// File: rtl/calc_mp_engine.sv
// Multi-port calculator: NUM_PORTS two-cycle requesters share one ALU through a round-robin arbiter.
// Optional feature macro: CALC_MUL_EN adds cmd 0011 (unsigned multiply, overflow on any high product bit).
module calc_mp_engine #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                         c_clk,
    input  logic                         reset,
    input  logic [0:NUM_PORTS*4-1]       req_cmd_in,
    input  logic [0:NUM_PORTS*DATA_W-1]  req_data_in,
    output logic [0:NUM_PORTS*2-1]       out_resp,
    output logic [0:NUM_PORTS*DATA_W-1]  out_data
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_ADD  = 4'b0001;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_MUL  = 4'b0011;
    localparam logic [3:0] CMD_SHL  = 4'b0101;
    localparam logic [3:0] CMD_SHR  = 4'b0110;

    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP2  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    // Per-port state is kept in r_state so checkers can bind to it directly.
    state_t             r_state     [NUM_PORTS];
    state_t             w_state_nxt [NUM_PORTS];
    logic [3:0]         r_cmd       [NUM_PORTS];
    logic [DATA_W-1:0]  r_op1       [NUM_PORTS];
    logic [DATA_W-1:0]  r_op2       [NUM_PORTS];
    logic [1:0]         r_resp      [NUM_PORTS];
    logic [DATA_W-1:0]  r_data      [NUM_PORTS];
    logic [PTR_W-1:0]   r_ptr;

    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [PTR_W-1:0]   w_cand;
    logic [3:0]         w_cmd;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [DATA_W:0]    w_sum;
    logic [1:0]         w_res_resp;
    logic [DATA_W-1:0]  w_res_data;
`ifdef CALC_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
`endif

    // Round-robin: first pending port at or after the pointer, wrapping.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NUM_PORTS);
            if (!w_gnt_vld && r_state[w_cand] == S_PEND) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_state_nxt[p] = r_state[p];
            case (r_state[p])
                S_IDLE:  if (req_cmd_in[p*4 +: 4] != CMD_NONE) w_state_nxt[p] = S_OP2;
                S_OP2:   w_state_nxt[p] = S_PEND;
                S_PEND:  if (w_gnt_vld && w_gnt_idx == PTR_W'(p)) w_state_nxt[p] = S_IDLE;
                default: w_state_nxt[p] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cmd      = r_cmd[w_gnt_idx];
        w_a        = r_op1[w_gnt_idx];
        w_b        = r_op2[w_gnt_idx];
        w_sum      = {1'b0, w_a} + {1'b0, w_b};
        w_res_resp = RESP_ERR;
        w_res_data = '0;
`ifdef CALC_MUL_EN
        w_prod     = w_a * w_b;
`endif
        case (w_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (w_b <= w_a) begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_a - w_b;
                end
            end
            CMD_SHL: begin
                w_res_resp = RESP_OK;
                w_res_data = w_a << w_b[SH_W-1:0];
            end
            CMD_SHR: begin
                w_res_resp = RESP_OK;
                w_res_data = w_a >> w_b[SH_W-1:0];
            end
`ifdef CALC_MUL_EN
            CMD_MUL: begin
                if (w_prod[2*DATA_W-1:DATA_W] == '0) begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_prod[DATA_W-1:0];
                end
            end
`endif
            default: begin
                w_res_resp = RESP_ERR;
                w_res_data = '0;
            end
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_ptr <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_state[p] <= S_IDLE;
                r_cmd[p]   <= CMD_NONE;
                r_op1[p]   <= '0;
                r_op2[p]   <= '0;
                r_resp[p]  <= 2'b00;
                r_data[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_state[p] <= w_state_nxt[p];
                r_resp[p]  <= 2'b00;
                r_data[p]  <= '0;
                if (r_state[p] == S_IDLE && req_cmd_in[p*4 +: 4] != CMD_NONE) begin
                    r_cmd[p] <= req_cmd_in[p*4 +: 4];
                    r_op1[p] <= req_data_in[p*DATA_W +: DATA_W];
                end
                if (r_state[p] == S_OP2) begin
                    r_op2[p] <= req_data_in[p*DATA_W +: DATA_W];
                end
            end
            if (w_gnt_vld) begin
                r_resp[w_gnt_idx] <= w_res_resp;
                r_data[w_gnt_idx] <= w_res_data;
                if (w_gnt_idx == PTR_W'(NUM_PORTS - 1)) r_ptr <= '0;
                else                                     r_ptr <= w_gnt_idx + 1'b1;
            end
        end
    end

    always_comb begin
        out_resp = '0;
        out_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            out_resp[p*2 +: 2]           = r_resp[p];
            out_data[p*DATA_W +: DATA_W] = r_data[p];
        end
    end

endmodule
